car_scan_controller: RTL and testbench

Parametrised single-car elevator controller and the next generation of the fixed-size two-car main controller. It latches hall and car calls for any floor count and tracks its own floor position with a travel timer. It serves calls in collective (SCAN) order and drives the door with a dwell timer and obstruction reopen. The building-level dispatcher instantiates one per car and routes hall calls to it.

---
 rtl/car_scan_controller.sv | 206 ++++++++++++++++++++
 tb/tb_car_scan_controller.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/car_scan_controller.sv
// Single-car SCAN elevator controller: latches hall/car calls, tracks position, runs the door.
// Latency: a call latched at edge n is acted on at edge n+1; floor moves take TRAVEL_CYCLES edges.
// Backpressure: none; calls are level/pulse requests absorbed into pending bits, door_block holds the door.
module car_scan_controller #(
    parameter int NUM_FLOORS    = 8,
    parameter int FLOOR_W       = $clog2(NUM_FLOORS),
    parameter int DOOR_CYCLES   = 4,
    parameter int TRAVEL_CYCLES = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_FLOORS-1:0]   up_call,
    input  logic [NUM_FLOORS-1:0]   down_call,
    input  logic [NUM_FLOORS-1:0]   car_call,
    input  logic                    door_closed,
    input  logic                    door_block,
    output logic                    up,
    output logic                    down,
    output logic                    stop,
    output logic                    door_open,
    output logic [FLOOR_W-1:0]      current_floor,
    output logic                    dir,
    output logic [3*NUM_FLOORS-1:0] pending
);

    localparam int DCW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam int TCW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam logic [DCW-1:0] DOOR_LAST   = DCW'(DOOR_CYCLES - 1);
    localparam logic [TCW-1:0] TRAVEL_LAST = TCW'(TRAVEL_CYCLES - 1);

    // No up call exists at the top floor and no down call at the bottom floor.
    localparam logic [NUM_FLOORS-1:0] UP_MASK = {1'b0, {(NUM_FLOORS-1){1'b1}}};
    localparam logic [NUM_FLOORS-1:0] DN_MASK = {{(NUM_FLOORS-1){1'b1}}, 1'b0};

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_MOVE_UP    = 3'd1;
    localparam logic [2:0] ST_MOVE_DN    = 3'd2;
    localparam logic [2:0] ST_DOOR_OPEN  = 3'd3;
    localparam logic [2:0] ST_DOOR_CLOSE = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [FLOOR_W-1:0]    floor_q, floor_d;
    logic                  dir_q, dir_d;
    logic [NUM_FLOORS-1:0] up_pend_q, up_pend_d;
    logic [NUM_FLOORS-1:0] dn_pend_q, dn_pend_d;
    logic [NUM_FLOORS-1:0] car_pend_q, car_pend_d;
    logic [DCW-1:0]        dwell_q, dwell_d;
    logic [TCW-1:0]        travel_q, travel_d;

    logic [NUM_FLOORS-1:0] up_req, dn_req, floor_oh_q, suppress;
    logic [NUM_FLOORS-1:0] up_set, dn_set, car_set;
    logic                  in_door, same_floor_call;

    logic [NUM_FLOORS-1:0] all_pend, floor_oh_d;
    logic [NUM_FLOORS-1:0] with_clr, against_clr, up_clr, dn_clr, car_clr;
    logic                  arrive, above, below;
    logic                  here_car, here_up, here_dn, here_with, here_against, beyond;
    logic                  open_entry, serve_idle, flip;

    // Condition incoming calls: mask impossible hall calls, divert same-floor calls at an open door into a dwell restart.
    always_comb begin
        up_req          = up_call & UP_MASK;
        dn_req          = down_call & DN_MASK;
        in_door         = (state_q == ST_DOOR_OPEN) || (state_q == ST_DOOR_CLOSE);
        floor_oh_q      = NUM_FLOORS'(1) << floor_q;
        same_floor_call = in_door && ((up_req | dn_req | car_call) & floor_oh_q) != '0;
        suppress        = in_door ? floor_oh_q : '0;
        up_set          = up_req & ~suppress;
        dn_set          = dn_req & ~suppress;
        car_set         = car_call & ~suppress;
    end

    // Next-state: position/travel, SCAN decisions, door dwell, and service clearing on door-open entry.
    always_comb begin
        state_d    = state_q;
        floor_d    = floor_q;
        dir_d      = dir_q;
        dwell_d    = dwell_q;
        travel_d   = travel_q;
        arrive     = 1'b0;
        open_entry = 1'b0;
        serve_idle = 1'b0;
        all_pend   = up_pend_q | dn_pend_q | car_pend_q;

        if ((state_q == ST_MOVE_UP) || (state_q == ST_MOVE_DN)) begin
            if (travel_q == TRAVEL_LAST) begin
                travel_d = '0;
                arrive   = 1'b1;
                floor_d  = (state_q == ST_MOVE_UP) ? floor_q + 1'b1 : floor_q - 1'b1;
            end else begin
                travel_d = travel_q + 1'b1;
            end
        end

        // Everything below is judged at the floor the car occupies after this edge.
        above = 1'b0;
        below = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (FLOOR_W'(i) > floor_d) above = above | all_pend[i];
            if (FLOOR_W'(i) < floor_d) below = below | all_pend[i];
        end
        here_car     = car_pend_q[floor_d];
        here_up      = up_pend_q[floor_d];
        here_dn      = dn_pend_q[floor_d];
        here_with    = dir_q ? here_dn : here_up;
        here_against = dir_q ? here_up : here_dn;
        beyond       = dir_q ? below : above;

        case (state_q)
            ST_IDLE: begin
                if (here_car || here_up || here_dn) begin
                    state_d    = ST_DOOR_OPEN;
                    open_entry = 1'b1;
                    serve_idle = 1'b1;
                end else if (above && (!dir_q || !below)) begin
                    state_d = ST_MOVE_UP;
                    dir_d   = 1'b0;
                end else if (below) begin
                    state_d = ST_MOVE_DN;
                    dir_d   = 1'b1;
                end
            end
            ST_MOVE_UP, ST_MOVE_DN: begin
                if (arrive) begin
                    if (here_car || here_with || (here_against && !beyond)) begin
                        state_d    = ST_DOOR_OPEN;
                        open_entry = 1'b1;
                    end else if (!beyond) begin
                        // Nothing left to travel toward; park rather than run off the shaft.
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DOOR_OPEN: begin
                if (door_block || same_floor_call) begin
                    dwell_d = '0;
                end else if (dwell_q == DOOR_LAST) begin
                    dwell_d = '0;
                    state_d = ST_DOOR_CLOSE;
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            ST_DOOR_CLOSE: begin
                if (door_block || same_floor_call) begin
                    dwell_d = '0;
                    state_d = ST_DOOR_OPEN;
                end else if (door_closed) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Serving the opposite hall call turns the car around. From IDLE it also does so when that is
        // the only hall call here, otherwise the stranded call would reopen the door forever.
        flip        = open_entry && here_against && (!beyond || (serve_idle && !here_with));
        floor_oh_d  = NUM_FLOORS'(1) << floor_d;
        car_clr     = open_entry ? floor_oh_d : '0;
        with_clr    = open_entry ? floor_oh_d : '0;
        against_clr = (open_entry && (!beyond || flip)) ? floor_oh_d : '0;
        up_clr      = dir_q ? against_clr : with_clr;
        dn_clr      = dir_q ? with_clr : against_clr;
        if (flip) dir_d = ~dir_q;
        if (open_entry) dwell_d = '0;

        // Clear wins over a same-cycle set.
        up_pend_d  = (up_pend_q | up_set) & ~up_clr;
        dn_pend_d  = (dn_pend_q | dn_set) & ~dn_clr;
        car_pend_d = (car_pend_q | car_set) & ~car_clr;
    end

    // State registers with synchronous reset to floor 0, no calls.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            floor_q    <= '0;
            dir_q      <= 1'b0;
            up_pend_q  <= '0;
            dn_pend_q  <= '0;
            car_pend_q <= '0;
            dwell_q    <= '0;
            travel_q   <= '0;
        end else begin
            state_q    <= state_d;
            floor_q    <= floor_d;
            dir_q      <= dir_d;
            up_pend_q  <= up_pend_d;
            dn_pend_q  <= dn_pend_d;
            car_pend_q <= car_pend_d;
            dwell_q    <= dwell_d;
            travel_q   <= travel_d;
        end
    end

    assign up            = (state_q == ST_MOVE_UP);
    assign down          = (state_q == ST_MOVE_DN);
    assign stop          = !(up || down);
    assign door_open     = (state_q == ST_DOOR_OPEN);
    assign current_floor = floor_q;
    assign dir           = dir_q;
    assign pending       = {car_pend_q, dn_pend_q, up_pend_q};

endmodule

// File: tb/tb_car_scan_controller.sv
// Directed bench for car_scan_controller (8 floors, dwell 4, travel 3).
// Table of per-cycle vectors followed by multi-cycle scenario sequences.
// Outputs sampled 1 time unit after each rising edge.
module tb_car_scan_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  up_call, down_call, car_call;
    logic        door_closed, door_block;
    logic        up, down, stop, door_open, dir;
    logic [2:0]  current_floor;
    logic [23:0] pending;

    int checks   = 0;
    int failures = 0;

    car_scan_controller dut (
        .clk           (clk),
        .rst           (rst),
        .up_call       (up_call),
        .down_call     (down_call),
        .car_call      (car_call),
        .door_closed   (door_closed),
        .door_block    (door_block),
        .up            (up),
        .down          (down),
        .stop          (stop),
        .door_open     (door_open),
        .current_floor (current_floor),
        .dir           (dir),
        .pending       (pending)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic [7:0]  uc;
        logic [7:0]  dc;
        logic [7:0]  cc;
        logic        blk;
        logic        dcl;
        logic [2:0]  fl;
        logic        up_e;
        logic        dn_e;
        logic        door_e;
        logic        dir_e;
        logic [23:0] pend_e;
    } vec_t;

    localparam int NV = 32;
    vec_t tbl [NV];

    function automatic vec_t mkv(input logic r, input logic [7:0] uc, input logic [7:0] dc,
                                 input logic [7:0] cc, input logic blk, input logic dcl,
                                 input logic [2:0] fl, input logic u, input logic d,
                                 input logic dr, input logic ds, input logic [23:0] p);
        vec_t v;
        v.rst = r; v.uc = uc; v.dc = dc; v.cc = cc; v.blk = blk; v.dcl = dcl;
        v.fl = fl; v.up_e = u; v.dn_e = d; v.door_e = dr; v.dir_e = ds; v.pend_e = p;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_door(input string name, output int fl);
        int n;
        n = 0;
        while (door_open !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (door_open !== 1'b1) begin
            failures++;
            $display("FAIL %s: door_open=%b after %0d cycles, expected 1", name, door_open, n);
        end
        fl = int'(current_floor);
    endtask

    task automatic wait_close(input string name);
        int n;
        n = 0;
        while (door_open !== 1'b0 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (door_open !== 1'b0) begin
            failures++;
            $display("FAIL %s: door_open=%b after %0d cycles, expected 0", name, door_open, n);
        end
        tick();
    endtask

    initial begin
        int fl;
        int n;
        logic held;

        rst = 1'b1; up_call = '0; down_call = '0; car_call = '0;
        door_closed = 1'b1; door_block = 1'b0;

        //          rst uc     dc cc     blk dcl fl up dn door dir pend
        tbl[0]  = mkv(1, 0,     0, 0,     0, 1, 0, 0, 0, 0, 0, 24'h000000);
        tbl[1]  = mkv(1, 0,     0, 0,     0, 1, 0, 0, 0, 0, 0, 24'h000000);
        tbl[2]  = mkv(0, 0,     0, 8'h08, 0, 1, 0, 0, 0, 0, 0, 24'h080000);
        tbl[3]  = mkv(0, 0,     0, 0,     0, 1, 0, 1, 0, 0, 0, 24'h080000);
        tbl[4]  = mkv(0, 0,     0, 0,     0, 1, 0, 1, 0, 0, 0, 24'h080000);
        tbl[5]  = mkv(0, 0,     0, 0,     0, 1, 0, 1, 0, 0, 0, 24'h080000);
        tbl[6]  = mkv(0, 0,     0, 0,     0, 1, 1, 1, 0, 0, 0, 24'h080000);
        tbl[7]  = mkv(0, 0,     0, 0,     0, 1, 1, 1, 0, 0, 0, 24'h080000);
        tbl[8]  = mkv(0, 0,     0, 0,     0, 1, 1, 1, 0, 0, 0, 24'h080000);
        tbl[9]  = mkv(0, 0,     0, 0,     0, 1, 2, 1, 0, 0, 0, 24'h080000);
        tbl[10] = mkv(0, 0,     0, 0,     0, 1, 2, 1, 0, 0, 0, 24'h080000);
        tbl[11] = mkv(0, 0,     0, 0,     0, 1, 2, 1, 0, 0, 0, 24'h080000);
        tbl[12] = mkv(0, 0,     0, 0,     0, 1, 3, 0, 0, 1, 0, 24'h000000);
        tbl[13] = mkv(0, 0,     0, 0,     0, 1, 3, 0, 0, 1, 0, 24'h000000);
        tbl[14] = mkv(0, 0,     0, 0,     0, 1, 3, 0, 0, 1, 0, 24'h000000);
        tbl[15] = mkv(0, 0,     0, 0,     0, 1, 3, 0, 0, 1, 0, 24'h000000);
        tbl[16] = mkv(0, 0,     0, 0,     0, 1, 3, 0, 0, 0, 0, 24'h000000);
        tbl[17] = mkv(0, 0,     0, 0,     0, 1, 3, 0, 0, 0, 0, 24'h000000);
        tbl[18] = mkv(0, 8'h08, 0, 0,     0, 1, 3, 0, 0, 0, 0, 24'h000008);
        tbl[19] = mkv(0, 0,     0, 0,     0, 1, 3, 0, 0, 1, 0, 24'h000000);
        tbl[20] = mkv(0, 0,     0, 8'h08, 0, 1, 3, 0, 0, 1, 0, 24'h000000);
        tbl[21] = mkv(0, 0,     0, 0,     0, 1, 3, 0, 0, 1, 0, 24'h000000);
        tbl[22] = mkv(0, 0,     0, 0,     0, 1, 3, 0, 0, 1, 0, 24'h000000);
        tbl[23] = mkv(0, 0,     0, 0,     0, 1, 3, 0, 0, 1, 0, 24'h000000);
        tbl[24] = mkv(0, 0,     0, 0,     0, 1, 3, 0, 0, 0, 0, 24'h000000);
        tbl[25] = mkv(0, 0,     0, 0,     0, 0, 3, 0, 0, 0, 0, 24'h000000);
        tbl[26] = mkv(0, 0,     0, 0,     1, 0, 3, 0, 0, 1, 0, 24'h000000);
        tbl[27] = mkv(0, 0,     0, 0,     0, 0, 3, 0, 0, 1, 0, 24'h000000);
        tbl[28] = mkv(0, 0,     0, 0,     0, 0, 3, 0, 0, 1, 0, 24'h000000);
        tbl[29] = mkv(0, 0,     0, 0,     0, 0, 3, 0, 0, 1, 0, 24'h000000);
        tbl[30] = mkv(0, 0,     0, 0,     0, 0, 3, 0, 0, 0, 0, 24'h000000);
        tbl[31] = mkv(0, 0,     0, 0,     0, 1, 3, 0, 0, 0, 0, 24'h000000);

        for (int i = 0; i < NV; i++) begin
            rst = tbl[i].rst; up_call = tbl[i].uc; down_call = tbl[i].dc; car_call = tbl[i].cc;
            door_block = tbl[i].blk; door_closed = tbl[i].dcl;
            tick();
            chk($sformatf("vec%0d {up,down,stop,door,floor,dir,pend}", i),
                {up, down, stop, door_open, current_floor, dir, pending},
                {tbl[i].up_e, tbl[i].dn_e, !(tbl[i].up_e || tbl[i].dn_e), tbl[i].door_e,
                 tbl[i].fl, tbl[i].dir_e, tbl[i].pend_e});
        end
        up_call = '0; down_call = '0; car_call = '0; door_block = 1'b0; door_closed = 1'b1;

        // Reset in the middle of a trip from floor 3 toward car_call[5].
        car_call = 8'h20; tick(); car_call = '0;
        tick();
        chk("reset_depart_up", {31'd0, up}, 32'd1);
        repeat (3) tick();
        chk("reset_floor4", {29'd0, current_floor}, 32'd4);
        rst = 1'b1;
        tick();
        chk("reset_edge1 {up,stop,door,floor,dir,pend}",
            {up, stop, door_open, current_floor, dir, pending}, {1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 24'h0});
        tick();
        chk("reset_edge2 {up,stop,door,floor,dir,pend}",
            {up, stop, door_open, current_floor, dir, pending}, {1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 24'h0});
        rst = 1'b0;

        // Same-floor call at floor 0 plus the two impossible hall calls.
        up_call = 8'h81; down_call = 8'h01; tick(); up_call = '0; down_call = '0;
        chk("mask_pending", pending, 24'h000001);
        tick();
        chk("same_floor_open {up,down,door,pend}", {up, down, door_open, pending},
            {1'b0, 1'b0, 1'b1, 24'h0});
        wait_close("same_floor_close");

        // SCAN order from floor 0: expect stops 3, 5 going up, then 2 going down.
        up_call = 8'h08; car_call = 8'h20; down_call = 8'h04; tick();
        up_call = '0; car_call = '0; down_call = '0;
        chk("scan_latched", pending, 24'h200408);
        wait_door("scan_stop1", fl);
        chk("scan_stop1_floor_dir", {fl[30:0], dir}, {31'd3, 1'b0});
        wait_close("scan_close1");
        wait_door("scan_stop2", fl);
        chk("scan_stop2_floor_dir", {fl[30:0], dir}, {31'd5, 1'b0});
        wait_close("scan_close2");
        wait_door("scan_stop3", fl);
        chk("scan_stop3_floor_dir", {fl[30:0], dir}, {31'd2, 1'b1});
        chk("scan_all_cleared", pending, 24'h0);
        wait_close("scan_close3");

        // Obstruction at floor 2 with door_closed low so DOOR_CLOSE is observable.
        door_closed = 1'b0;
        car_call = 8'h04; tick(); car_call = '0;
        tick();
        chk("block_open", {31'd0, door_open}, 32'd1);
        held = 1'b1;
        door_block = 1'b1;
        repeat (5) begin
            tick();
            held = held & door_open;
        end
        chk("block_held", {31'd0, held}, 32'd1);
        door_block = 1'b0;
        n = 0;
        while (n < 20) begin
            tick();
            n++;
            if (door_open === 1'b0) break;
        end
        chk("block_release_dwell", n, 32'd4);
        tick();
        chk("close_wait_sensor {door,stop}", {30'd0, door_open, stop}, {30'd0, 1'b0, 1'b1});
        door_block = 1'b1; tick(); door_block = 1'b0;
        chk("close_block_reopen", {31'd0, door_open}, 32'd1);
        door_closed = 1'b1;
        wait_close("reopen_close");

        // Car at 2 heading down with only down_call[6]: goes up, serves it, turns around.
        down_call = 8'h40; tick(); down_call = '0;
        chk("rev_latched", pending, 24'h004000);
        tick();
        chk("rev_depart {up,dir}", {30'd0, up, dir}, {30'd0, 1'b1, 1'b0});
        wait_door("rev_stop", fl);
        chk("rev_stop {floor,dir,pend}", {fl[6:0], dir, pending}, {7'd6, 1'b1, 24'h0});
        wait_close("rev_close");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
